// File: rtl/multdiv_pipe_unit.sv
// Iterative signed multiply/divide unit with valid/ready handshake, tag passthrough and flush.
// Magnitudes are processed unsigned; the sign is applied in a single fix-up cycle.
module multdiv_pipe_unit #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_div,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             exception,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [CW-1:0]        count;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic                 neg;
    logic                 is_div;
    logic [2*WIDTH-1:0]   acc;

    logic                 accept;
    logic                 last_iter;
    logic [WIDTH-1:0]     in_mag_a;
    logic [WIDTH-1:0]     in_mag_b;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_step;
    logic [WIDTH:0]       rem_s;
    logic [WIDTH:0]       div_diff;
    logic [2*WIDTH-1:0]   div_step;
    logic [2*WIDTH-1:0]   prod_signed;
    logic [WIDTH-1:0]     quo_signed;
    logic [WIDTH-1:0]     fix_result;
    logic                 fix_exc;

    assign accept    = in_valid & in_ready & ~flush;
    assign last_iter = (count == CW'(WIDTH - 1));
    assign in_mag_a  = operand_a[WIDTH-1] ? -operand_a : operand_a;
    assign in_mag_b  = operand_b[WIDTH-1] ? -operand_b : operand_b;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (!op_div)              state_nxt = S_MUL;
                        else if (operand_b == '0) state_nxt = S_FIX;
                        else                      state_nxt = S_DIV;
                    end
                end
                S_MUL, S_DIV: if (last_iter) state_nxt = S_FIX;
                S_FIX:        state_nxt = S_DONE;
                S_DONE:       if (out_ready) state_nxt = S_IDLE;
                default:      state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state == S_IDLE);
        busy      = (state != S_IDLE);
        out_valid = (state == S_DONE);
    end

    // Shift-add: low half holds the remaining multiplier bits, high half the partial sum.
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : '0);
    assign mul_step = {mul_sum, acc[WIDTH-1:1]};

    // Restoring divide: high half is the remainder, low half shifts dividend out / quotient in.
    assign rem_s    = acc[2*WIDTH-1:WIDTH-1];
    assign div_diff = rem_s - {1'b0, mag_b};
    assign div_step = div_diff[WIDTH] ? {rem_s[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                      : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

    assign prod_signed = neg ? -acc : acc;
    assign quo_signed  = neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];

    // A positive quotient with the top bit set can only be |MIN|/1 with MIN / -1.
    always_comb begin
        fix_result = prod_signed[WIDTH-1:0];
        fix_exc    = (prod_signed[2*WIDTH-1:WIDTH] != {WIDTH{prod_signed[WIDTH-1]}});
        if (is_div) begin
            if (mag_b == '0) begin
                fix_result = '0;
                fix_exc    = 1'b1;
            end else begin
                fix_result = quo_signed;
                fix_exc    = ~neg & acc[WIDTH-1];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count     <= '0;
            mag_a     <= '0;
            mag_b     <= '0;
            neg       <= 1'b0;
            is_div    <= 1'b0;
            acc       <= '0;
            result    <= '0;
            exception <= 1'b0;
            out_tag   <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        count   <= '0;
                        mag_a   <= in_mag_a;
                        mag_b   <= in_mag_b;
                        neg     <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
                        is_div  <= op_div;
                        acc     <= {{WIDTH{1'b0}}, (op_div ? in_mag_a : in_mag_b)};
                        out_tag <= in_tag;
                    end
                end
                S_MUL: begin
                    acc   <= mul_step;
                    count <= count + 1'b1;
                end
                S_DIV: begin
                    acc   <= div_step;
                    count <= count + 1'b1;
                end
                S_FIX: begin
                    result    <= fix_result;
                    exception <= fix_exc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_pipe_unit.sv
// Self-checking bench for multdiv_pipe_unit: directed corner cases plus random ops
// compared against a plain-arithmetic signed multiply/divide model.
module tb_multdiv_pipe_unit;

    localparam int W = 32;
    localparam int T = 5;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         op_div = 1'b0;
    logic [W-1:0] operand_a = '0;
    logic [W-1:0] operand_b = '0;
    logic [T-1:0] in_tag = '0;
    logic         flush = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         exception;
    logic [T-1:0] out_tag;
    logic         busy;

    int checks = 0;
    int errors = 0;

    multdiv_pipe_unit #(.WIDTH(W), .TAG_W(T)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op_div(op_div), .operand_a(operand_a), .operand_b(operand_b), .in_tag(in_tag),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .exception(exception), .out_tag(out_tag), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic e);
        longint p;
        int     q;
        if (!op) begin
            p = longint'($signed(a)) * longint'($signed(b));
            r = p[W-1:0];
            e = (p != longint'($signed(p[W-1:0])));
        end else if (b == 0) begin
            r = '0;
            e = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = a;
            e = 1'b1;
        end else begin
            q = $signed(a) / $signed(b);
            r = q;
            e = 1'b0;
        end
    endfunction

    // Issue one op, measure latency, check the result, optionally hold it, then hand it off.
    task automatic run_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [T-1:0] tag, input int hold, input string name);
        logic [W-1:0] er;
        logic         ee;
        int           lat;
        int           exp_lat;
        int           guard;
        model(op, a, b, er, ee);
        exp_lat = (op && b == 0) ? 1 : W + 1;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clock);
            guard++;
        end
        chk({name, "_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1; op_div = op; operand_a = a; operand_b = b; in_tag = tag;
        @(negedge clock);
        in_valid = 1'b0;
        operand_a = $urandom; operand_b = $urandom;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(negedge clock);
            lat++;
        end
        chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({name, "_result"}, 64'(result), 64'(er));
        chk({name, "_exc"}, 64'(exception), 64'(ee));
        chk({name, "_tag"}, 64'(out_tag), 64'(tag));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; op_div = ~op; in_tag = ~tag;
            @(negedge clock);
            chk({name, "_hold_valid"}, 64'(out_valid), 64'd1);
            chk({name, "_hold_ready"}, 64'(in_ready), 64'd0);
            chk({name, "_hold_result"}, 64'(result), 64'(er));
            chk({name, "_hold_exc"}, 64'(exception), 64'(ee));
            chk({name, "_hold_tag"}, 64'(out_tag), 64'(tag));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        chk({name, "_handoff_ready"}, 64'(in_ready), 64'd1);
        chk({name, "_handoff_valid"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int           seen;

        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_exc", 64'(exception), 64'd0);
        chk("rst_tag", 64'(out_tag), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);

        run_op(1'b0, 32'd7, -32'sd3, 5'd9, 0, "mul_7x-3");
        run_op(1'b0, 32'h0001_0000, 32'h0001_0000, 5'd1, 0, "mul_ovf");
        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 0, "mul_m1xm1");
        run_op(1'b1, -32'sd7, 32'd2, 5'd3, 0, "div_-7/2");
        run_op(1'b1, 32'd5, 32'd0, 5'd4, 0, "div_by0");
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5, 0, "div_min");
        run_op(1'b1, 32'd100, 32'd7, 5'd6, 0, "div_100/7");
        run_op(1'b1, 32'h8000_0000, 32'd1, 5'd7, 0, "div_min/1");
        run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 0, "mul_minxm1");

        // Flush mid-multiply: nothing must come out.
        in_valid = 1'b1; op_div = 1'b0; operand_a = 32'd11; operand_b = 32'd13; in_tag = 5'd10;
        @(negedge clock);
        in_valid = 1'b0;
        repeat (10) @(negedge clock);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        chk("flush_busy", 64'(busy), 64'd0);
        seen = 0;
        for (int i = 0; i < W + 8; i++) begin
            @(negedge clock);
            if (out_valid) seen++;
        end
        chk("flush_no_valid", 64'(seen), 64'd0);
        run_op(1'b0, 32'd3, 32'd4, 5'd11, 0, "mul_3x4");

        // Asynchronous reset mid-divide clears outputs without waiting for an edge.
        in_valid = 1'b1; op_div = 1'b1; operand_a = 32'd1000; operand_b = 32'd3; in_tag = 5'd12;
        @(negedge clock);
        in_valid = 1'b0;
        repeat (5) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk("arst_result", 64'(result), 64'd0);
        chk("arst_exc", 64'(exception), 64'd0);
        chk("arst_tag", 64'(out_tag), 64'd0);
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("arst_in_ready", 64'(in_ready), 64'd1);

        run_op(1'b0, 32'd123, -32'sd45, 5'd13, 5, "hold_mul");
        run_op(1'b1, -32'sd1000, 32'd0, 5'd14, 3, "hold_div0");

        for (int n = 0; n < 30; n++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = $urandom;
                1: rb = $urandom_range(0, 20) - 10;
                2: rb = 32'h0000_FFFF & $urandom;
                default: rb = 32'hFFFF_FFFF;
            endcase
            if ($urandom_range(0, 4) == 0) ra = 32'h8000_0000;
            run_op(1'($urandom_range(0, 1)), ra, rb, 5'($urandom), 0, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
